display_scan_ctrl: RTL

Time-multiplexed scan controller for the calculator's 8-digit seven-segment display. It latches a display request (BCD number with decimal point, or a fixed message/brightness code) and commits it only at frame boundaries, so a digit never shows a partly updated value. It scans the digits one at a time and dims them with quarter-slot PWM. It sits between the calculator core and the board display pins.

---
 rtl/display_scan_ctrl_if.sv | 28 ++
 rtl/display_scan_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl_if.sv
// Request/display bundle between the calculator core and the scan controller.
// Latency: none (wires only).
// Backpressure: none; a load strobe is always accepted.
// Ports: load/mode/dp/code/num carry a display request from the core;
//        digit_en/seg/seg_dp/frame_done carry the scanned display output.
interface display_scan_ctrl_if;
  logic        load;
  logic        mode;
  logic [2:0]  dp;
  logic [3:0]  code;
  logic [31:0] num;
  logic [7:0]  digit_en;
  logic [6:0]  seg;
  logic        seg_dp;
  logic        frame_done;

  // Core side: issues requests, observes the display pins.
  modport master (
    output load, mode, dp, code, num,
    input  digit_en, seg, seg_dp, frame_done
  );

  // Scan controller side.
  modport slave (
    input  load, mode, dp, code, num,
    output digit_en, seg, seg_dp, frame_done
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// 8-digit seven-segment scan controller with frame-boundary commit and quarter-slot PWM dimming.
// Latency: outputs registered (1 cycle after scan state); a request shows from digit 0 of the next frame.
// Backpressure: none; every load is accepted, a later load before commit overwrites the pending one.
// Ports: clk (rising edge), rst (async, active-low), bus (slave modport: load/mode/dp/code/num in,
//        digit_en/seg/seg_dp/frame_done out). DIV = clk cycles per digit slot, multiple of 4, >= 4.
module display_scan_ctrl #(
  parameter int DIV = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  display_scan_ctrl_if.slave   bus
);

  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int QTR = DIV / 4;

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [1:0]    bright;

  // Pending request, overwritten by every load.
  logic          pend_mode;
  logic [2:0]    pend_dp;
  logic [3:0]    pend_code;
  logic [31:0]   pend_num;

  // Content currently on the display.
  logic          act_mode;
  logic [2:0]    act_dp;
  logic [3:0]    act_code;
  logic [31:0]   act_num;

  // Commit-side view: a load on the commit cycle bypasses pending.
  logic          commit;
  logic          c_mode;
  logic [2:0]    c_dp;
  logic [3:0]    c_code;
  logic [31:0]   c_num;

  logic [3:0]    nib;
  logic [31:0]   upper;
  logic          lit;
  logic [6:0]    seg_n;
  logic          dp_n;

  always_comb begin
    commit = (idx == 3'd7) && (cnt == CW'(DIV - 1));
    c_mode = bus.load ? bus.mode : pend_mode;
    c_dp   = bus.load ? bus.dp   : pend_dp;
    c_code = bus.load ? bus.code : pend_code;
    c_num  = bus.load ? bus.num  : pend_num;
  end

  always_comb begin
    nib   = act_num[{idx, 2'b00} +: 4];
    // Nibbles above the current digit; shifting by 32 for digit 7 yields 0.
    upper = act_num >> (6'({idx, 2'b00}) + 6'd4);
    lit   = 32'(cnt) < ((32'(bright) + 32'd1) * 32'(QTR));
    seg_n = 7'h00;
    dp_n  = 1'b0;
    if (!act_mode) begin
      // Leading zeros are blanked, but never at or below the decimal point.
      if (!((nib == 4'd0) && (upper == 32'd0) && (idx > act_dp))) begin
        dp_n = (idx == act_dp);
        case (nib)
          4'h0:    seg_n = 7'h3F;
          4'h1:    seg_n = 7'h06;
          4'h2:    seg_n = 7'h5B;
          4'h3:    seg_n = 7'h4F;
          4'h4:    seg_n = 7'h66;
          4'h5:    seg_n = 7'h6D;
          4'h6:    seg_n = 7'h7D;
          4'h7:    seg_n = 7'h07;
          4'h8:    seg_n = 7'h7F;
          4'h9:    seg_n = 7'h6F;
          4'hA:    seg_n = 7'h40;
          default: begin
            // B..F are blank, including the decimal point.
            seg_n = 7'h00;
            dp_n  = 1'b0;
          end
        endcase
      end
    end else begin
      if (act_code == 4'd4) begin
        case (idx)
          3'd3:    seg_n = 7'h76;
          3'd2:    seg_n = 7'h3F;
          3'd1:    seg_n = 7'h38;
          3'd0:    seg_n = 7'h77;
          default: seg_n = 7'h00;
        endcase
      end else if (act_code == 4'd5) begin
        case (idx)
          3'd3:    seg_n = 7'h39;
          3'd2:    seg_n = 7'h76;
          3'd1:    seg_n = 7'h77;
          3'd0:    seg_n = 7'h3E;
          default: seg_n = 7'h00;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt            <= '0;
      idx            <= 3'd0;
      bright         <= 2'd3;
      pend_mode      <= 1'b0;
      pend_dp        <= 3'd0;
      pend_code      <= 4'd0;
      pend_num       <= 32'd0;
      act_mode       <= 1'b0;
      act_dp         <= 3'd0;
      act_code       <= 4'd0;
      act_num        <= 32'd0;
      bus.digit_en   <= 8'h00;
      bus.seg        <= 7'h00;
      bus.seg_dp     <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      if (bus.load) begin
        pend_mode <= bus.mode;
        pend_dp   <= bus.dp;
        pend_code <= bus.code;
        pend_num  <= bus.num;
      end

      if (cnt == CW'(DIV - 1)) begin
        cnt <= '0;
        idx <= idx + 3'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end

      if (commit) begin
        // Brightness codes leave the shown content untouched.
        if (c_mode && (c_code < 4'd4)) begin
          bright <= c_code[1:0];
        end else begin
          act_mode <= c_mode;
          act_dp   <= c_dp;
          act_code <= c_code;
          act_num  <= c_num;
        end
      end

      bus.digit_en   <= lit ? (8'h01 << idx) : 8'h00;
      bus.seg        <= seg_n;
      bus.seg_dp     <= dp_n;
      bus.frame_done <= commit;
    end
  end

endmodule
